// File: rtl/texel_fetch_sequencer_if.sv
// Bus bundle for the texel fetch sequencer: coordinate input, texture RAM
// read port and filter-side texel quad output.
interface texel_fetch_sequencer_if #(
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [USER_WIDTH-1:0] s_user;
    logic [31:0]           s_texS;
    logic [31:0]           s_texT;

    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_rdata;

    logic                  m_valid;
    logic                  m_ready;
    logic [USER_WIDTH-1:0] m_user;
    logic [31:0]           m_texel00;
    logic [31:0]           m_texel01;
    logic [31:0]           m_texel10;
    logic [31:0]           m_texel11;
    logic [15:0]           m_texelSubCoordS;
    logic [15:0]           m_texelSubCoordT;

    // Sequencer side
    modport slave (
        input  s_valid, s_user, s_texS, s_texT, mem_rdata, m_ready,
        output s_ready, mem_rd, mem_addr,
        output m_valid, m_user, m_texel00, m_texel01, m_texel10, m_texel11,
        output m_texelSubCoordS, m_texelSubCoordT
    );

    // Rasterizer / RAM / filter side
    modport master (
        output s_valid, s_user, s_texS, s_texT, mem_rdata, m_ready,
        input  s_ready, mem_rd, mem_addr,
        input  m_valid, m_user, m_texel00, m_texel01, m_texel10, m_texel11,
        input  m_texelSubCoordS, m_texelSubCoordT
    );
endinterface

// File: rtl/texel_fetch_sequencer.sv
// Bilinear texel fetch sequencer: maps a Q16.16 coordinate pair to four
// wrapped/clamped texel addresses, reads them one per cycle, emits the quad.
module texel_fetch_sequencer #(
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_LOG2   = 8
) (
    input  logic                    aclk,
    input  logic                    resetn,
    input  logic [3:0]              conf_widthLog2,
    input  logic [3:0]              conf_heightLog2,
    input  logic                    conf_clampS,
    input  logic                    conf_clampT,
    input  logic                    conf_filterEnable,
    texel_fetch_sequencer_if.slave  bus
);

    localparam int unsigned LINE_W = 2 * MAX_LOG2;
    localparam int unsigned CRD_W  = 17;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD00  = 3'd1,
        RD01  = 3'd2,
        RD10  = 3'd3,
        RD11  = 3'd4,
        DRAIN = 3'd5,
        OUT   = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                    w_accept;
    logic [3:0]              w_wlg;
    logic [3:0]              w_hlg;
    logic signed [CRD_W-1:0] w_x0;
    logic signed [CRD_W-1:0] w_x1;
    logic signed [CRD_W-1:0] w_y0;
    logic signed [CRD_W-1:0] w_y1;
    logic [MAX_LOG2-1:0]     w_cx0;
    logic [MAX_LOG2-1:0]     w_cx1;
    logic [MAX_LOG2-1:0]     w_cy0;
    logic [MAX_LOG2-1:0]     w_cy1;
    logic [ADDR_WIDTH-1:0]   w_addr00;
    logic [ADDR_WIDTH-1:0]   w_addr01;
    logic [ADDR_WIDTH-1:0]   w_addr10;
    logic [ADDR_WIDTH-1:0]   w_addr11;

    logic                    w_rd_nxt;
    logic [1:0]              w_rd_idx_nxt;
    logic [ADDR_WIDTH-1:0]   w_addr_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr01;
    logic [ADDR_WIDTH-1:0]   r_addr10;
    logic [ADDR_WIDTH-1:0]   r_addr11;
    logic                    r_filt;
    logic                    r_s_ready;
    logic                    r_m_valid;
    logic                    r_mem_rd;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [1:0]              r_rd_idx;
    logic                    r_pend;
    logic [1:0]              r_pend_idx;
    logic [USER_WIDTH-1:0]   r_user;
    logic [31:0]             r_tex00;
    logic [31:0]             r_tex01;
    logic [31:0]             r_tex10;
    logic [31:0]             r_tex11;
    logic [15:0]             r_sub_s;
    logic [15:0]             r_sub_t;

    // Map one signed texel coordinate onto [0, 2^lg) by wrap or clamp.
    function automatic logic [MAX_LOG2-1:0] f_coord(
        input logic signed [CRD_W-1:0] c,
        input logic [3:0]              lg,
        input logic                    clamp
    );
        logic [CRD_W-1:0] lim;
        logic [CRD_W-1:0] res;
        lim = (CRD_W'(1) << lg) - CRD_W'(1);
        if (!clamp) begin
            res = $unsigned(c) & lim;
        end else if (c[CRD_W-1]) begin
            res = '0;
        end else if ($unsigned(c) > lim) begin
            res = lim;
        end else begin
            res = $unsigned(c);
        end
        return MAX_LOG2'(res);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_addr(
        input logic [MAX_LOG2-1:0] y,
        input logic [MAX_LOG2-1:0] x,
        input logic [3:0]          lg
    );
        logic [LINE_W-1:0] a;
        a = (LINE_W'(y) << lg) | LINE_W'(x);
        return ADDR_WIDTH'(a);
    endfunction

    assign w_accept = bus.s_valid && r_s_ready;

    // Oversized texture dimensions saturate to the largest supported size.
    assign w_wlg = (conf_widthLog2  > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : conf_widthLog2;
    assign w_hlg = (conf_heightLog2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : conf_heightLog2;

    assign w_x0 = {bus.s_texS[31], bus.s_texS[31:16]};
    assign w_y0 = {bus.s_texT[31], bus.s_texT[31:16]};
    assign w_x1 = w_x0 + 17'sd1;
    assign w_y1 = w_y0 + 17'sd1;

    assign w_cx0 = f_coord(w_x0, w_wlg, conf_clampS);
    assign w_cx1 = f_coord(w_x1, w_wlg, conf_clampS);
    assign w_cy0 = f_coord(w_y0, w_hlg, conf_clampT);
    assign w_cy1 = f_coord(w_y1, w_hlg, conf_clampT);

    assign w_addr00 = f_addr(w_cy0, w_cx0, w_wlg);
    assign w_addr01 = f_addr(w_cy0, w_cx1, w_wlg);
    assign w_addr10 = f_addr(w_cy1, w_cx0, w_wlg);
    assign w_addr11 = f_addr(w_cy1, w_cx1, w_wlg);

    // State register
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the read strobe/address to be registered for it
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_nxt     = 1'b0;
        w_rd_idx_nxt = 2'd0;
        w_addr_nxt   = '0;

        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RD00;
            RD00:    w_state_nxt = r_filt ? RD01 : DRAIN;
            RD01:    w_state_nxt = RD10;
            RD10:    w_state_nxt = RD11;
            RD11:    w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = OUT;
            OUT:     if (bus.m_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // RD00 is only entered from IDLE, so its address comes straight from the input.
        case (w_state_nxt)
            RD00: begin
                w_rd_nxt     = 1'b1;
                w_rd_idx_nxt = 2'd0;
                w_addr_nxt   = w_addr00;
            end
            RD01: begin
                w_rd_nxt     = 1'b1;
                w_rd_idx_nxt = 2'd1;
                w_addr_nxt   = r_addr01;
            end
            RD10: begin
                w_rd_nxt     = 1'b1;
                w_rd_idx_nxt = 2'd2;
                w_addr_nxt   = r_addr10;
            end
            RD11: begin
                w_rd_nxt     = 1'b1;
                w_rd_idx_nxt = 2'd3;
                w_addr_nxt   = r_addr11;
            end
            default: ;
        endcase
    end

    // Registered handshake and RAM port
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_s_ready  <= 1'b1;
            r_m_valid  <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_rd_idx   <= 2'd0;
            r_pend     <= 1'b0;
            r_pend_idx <= 2'd0;
        end else begin
            r_s_ready  <= (w_state_nxt == IDLE);
            r_m_valid  <= (w_state_nxt == OUT);
            r_mem_rd   <= w_rd_nxt;
            r_mem_addr <= w_addr_nxt;
            r_rd_idx   <= w_rd_idx_nxt;
            r_pend     <= r_mem_rd;
            r_pend_idx <= r_rd_idx;
        end
    end

    // Transaction context latched at accept; read data lands one cycle after the strobe.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_addr01 <= '0;
            r_addr10 <= '0;
            r_addr11 <= '0;
            r_filt   <= 1'b0;
            r_user   <= '0;
            r_sub_s  <= '0;
            r_sub_t  <= '0;
            r_tex00  <= '0;
            r_tex01  <= '0;
            r_tex10  <= '0;
            r_tex11  <= '0;
        end else begin
            if (w_accept) begin
                r_addr01 <= w_addr01;
                r_addr10 <= w_addr10;
                r_addr11 <= w_addr11;
                r_filt   <= conf_filterEnable;
                r_user   <= bus.s_user;
                r_sub_s  <= conf_filterEnable ? bus.s_texS[15:0] : 16'd0;
                r_sub_t  <= conf_filterEnable ? bus.s_texT[15:0] : 16'd0;
            end
            if (r_pend) begin
                unique case (r_pend_idx)
                    2'd0: begin
                        r_tex00 <= bus.mem_rdata;
                        if (!r_filt) begin
                            r_tex01 <= bus.mem_rdata;
                            r_tex10 <= bus.mem_rdata;
                            r_tex11 <= bus.mem_rdata;
                        end
                    end
                    2'd1: r_tex01 <= bus.mem_rdata;
                    2'd2: r_tex10 <= bus.mem_rdata;
                    2'd3: r_tex11 <= bus.mem_rdata;
                endcase
            end
        end
    end

    assign bus.s_ready          = r_s_ready;
    assign bus.mem_rd           = r_mem_rd;
    assign bus.mem_addr         = r_mem_addr;
    assign bus.m_valid          = r_m_valid;
    assign bus.m_user           = r_user;
    assign bus.m_texel00        = r_tex00;
    assign bus.m_texel01        = r_tex01;
    assign bus.m_texel10        = r_tex10;
    assign bus.m_texel11        = r_tex11;
    assign bus.m_texelSubCoordS = r_sub_s;
    assign bus.m_texelSubCoordT = r_sub_t;

endmodule

// File: doc/texel_fetch_sequencer.md
Name: texel_fetch_sequencer

Overview:
- Sequences texel fetches for the bilinear texture filter stage.
- Accepts one texture coordinate pair per transaction and computes the four neighbouring texel addresses, applying wrap or clamp per axis.
- Issues the reads to a single-port texture RAM with fixed read latency, one per cycle, then presents texel00/01/10/11 plus the sub-texel fractions to the filter over a valid/ready handshake.
- Sits between the rasterizer's texture-coordinate output and the filter.

Parameters:
USER_WIDTH, 1, width of sideband passed through unchanged with each transaction
ADDR_WIDTH, 16, texture RAM word-address width; must be >= 2*MAX_LOG2
MAX_LOG2, 8, maximum log2 of texture width/height; larger conf values saturate to MAX_LOG2

Ports:
aclk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
conf_widthLog2  in  4  log2 texture width, sampled at accept
conf_heightLog2  in  4  log2 texture height, sampled at accept
conf_clampS  in  1  1=clamp S, 0=wrap S; sampled at accept
conf_clampT  in  1  1=clamp T, 0=wrap T; sampled at accept
conf_filterEnable  in  1  1=bilinear (4 reads), 0=nearest (1 read); sampled at accept
s_valid  in  1  coordinate valid
s_ready  out  1  coordinate accept
s_user  in  USER_WIDTH  sideband
s_texS  in  32  signed Q16.16 S coordinate in texel units
s_texT  in  32  signed Q16.16 T coordinate in texel units
mem_rd  out  1  read strobe
mem_addr  out  ADDR_WIDTH  read address
mem_rdata  in  32  read data; valid exactly 1 cycle after mem_rd
m_valid  out  1  texel quad valid
m_ready  in  1  downstream ready
m_user  out  USER_WIDTH  sideband
m_texel00, m_texel01, m_texel10, m_texel11  out  32 each  texels (x0,y0),(x1,y0),(x0,y1),(x1,y1)
m_texelSubCoordS  out  16  S fraction
m_texelSubCoordT  out  16  T fraction

Behaviour:
- Reset: state IDLE; s_ready=1; m_valid=0; mem_rd=0; mem_addr=0; all m_* data=0. Reset asserted mid-transaction aborts it; no data is output for the aborted transaction.
- States: IDLE, RD00, RD01, RD10, RD11, DRAIN, OUT.
- s_ready=1 only in IDLE. Accept on s_valid&&s_ready:
  - latch user, fractions (s_texS[15:0], s_texT[15:0]) and conf;
  - compute and register the four addresses;
  - next state RD00.
- Coordinates:
  - x0 = s_texS[31:16] signed; x1 = x0+1, computed 17-bit signed (no overflow). Same for y0/y1 from s_texT.
  - Wrap: take the low widthLog2 bits (two's complement, so -1 wraps to width-1).
  - Clamp: <0 gives 0; >width-1 gives width-1.
  - Address = (y << widthLog2) | x, zero-extended to ADDR_WIDTH.
  - A log2 of 0 means size 1: all x (or y) map to 0.
- Reads:
  - mem_rd=1 in RD00..RD11, with mem_addr = the corresponding address; one state per cycle; no memory backpressure.
  - mem_rdata is captured into the texel register of the read issued the previous cycle.
- Bilinear sequence: RD00, RD01, RD10, RD11, DRAIN, OUT. m_valid rises 5 cycles after the accepting edge.
- Nearest (conf_filterEnable=0) sequence: RD00, DRAIN, OUT.
  - m_valid rises 2 cycles after accept.
  - All four m_texel outputs equal the texel00 read.
  - Both SubCoord outputs are 0.
- OUT state:
  - m_valid=1; outputs are stable until m_valid&&m_ready.
  - On handshake go to IDLE; s_ready=1 the next cycle.
  - Minimum transaction spacing is 7 cycles bilinear, 4 cycles nearest.
- conf_* and s_* changes after accept have no effect on the in-flight transaction.

Test Plan:
- Wrap, width log2=3, height log2=2, bilinear, S=0x0007_8000, T=0x0001_4000 -> reads at addr 15,8,23,16 in consecutive cycles; m_valid 5 cycles after accept with those texels in order; SubCoordS=0x8000, SubCoordT=0x4000.
- Clamp both axes, same size, S=0xFFFE_8000, T=0x0003_C000 -> four reads all at addr 24; SubCoordS=0x8000, SubCoordT=0xC000.
- Nearest mode, S=0x0002_FFFF, T=0x0001_0000, wrap -> single read at addr 10; all four texels equal that data; SubCoords=0; m_valid 2 cycles after accept.
- Backpressure: hold m_ready=0 for 10 cycles in OUT -> m_valid and all outputs stable, s_ready=0, no mem_rd; release -> handshake, then IDLE with s_ready=1 next cycle.
- Reset pulse during RD01 -> mem_rd=0 immediately; m_valid stays 0; s_ready=1 after release; next transaction correct.
- Back-to-back with s_valid held high and m_ready=1, 3 transactions -> accepts 7 cycles apart; m_user and texels match each transaction in order.
